// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one subtract-and-shift per clock; define SIGNED_DIV_EN for two's complement operands.
module seq_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         div_by_zero
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0] dvd, dvs, quo, quo_n, a_in, b_in, q_fin, r_fin;
  logic [N:0] rem, rem_s, diff, rem_n;
  logic [CW-1:0] cnt;
  logic zb, last, accept;
  assign accept = state == IDLE && start;
  assign last = cnt == CW'(N-1);
  assign rem_s = {rem[N-1:0], dvd[N-1]};
  assign diff = rem_s - {1'b0, dvs};
  assign rem_n = diff[N] ? rem_s : diff;
  assign quo_n = {quo[N-2:0], ~diff[N]};
`ifdef SIGNED_DIV_EN
  logic sa, sb;
  // B==0 keeps raw A in the dividend register so R can return it unchanged
  assign a_in = (B != '0 && A[N-1]) ? -A : A;
  assign b_in = B[N-1] ? -B : B;
  assign q_fin = (sa ^ sb) ? -quo_n : quo_n;
  assign r_fin = sa ? -rem_n[N-1:0] : rem_n[N-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      sa <= 1'b0;
      sb <= 1'b0;
    end else if (accept) begin
      sa <= A[N-1];
      sb <= B[N-1];
    end
  end
`else
  assign a_in = A;
  assign b_in = B;
  assign q_fin = quo_n;
  assign r_fin = rem_n[N-1:0];
`endif
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? CALC : IDLE;
      CALC: state_n = (zb || last) ? DONE : CALC;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      zb <= 1'b0;
      Q <= '0;
      R <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvd <= a_in;
      dvs <= b_in;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      zb <= B == '0;
      div_by_zero <= 1'b0;
    end else if (state == CALC && zb) begin
      Q <= '1;
      R <= dvd;
      div_by_zero <= 1'b1;
    end else if (state == CALC) begin
      dvd <= dvd << 1;
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt + 1'b1;
      Q <= last ? q_fin : Q;
      R <= last ? r_fin : R;
    end
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider against an arithmetic model.
module tb_seq_divider;
  localparam int N = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [N-1:0] A = '0, B = '0;
  logic busy, done, div_by_zero;
  logic [N-1:0] Q, R;
  int vecs = 0, errs = 0, cyc = 0, done_at = 0, dones = 0;
  logic bm = 1'b0, edz = 1'b0, pdz = 1'b0;
  logic [N-1:0] eq = '0, er = '0, pq = '0, pr = '0;

  seq_divider #(.N(N)) dut (.clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Q(Q), .R(R), .div_by_zero(div_by_zero));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] q, output logic [N-1:0] r);
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
`ifdef SIGNED_DIV_EN
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      q = N'(sa / sb);
      r = N'(sa % sb);
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // cycle-accurate expectation: result appears N edges (1 for B==0) after accept, held otherwise
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      bm = 1'b0;
      eq = '0;
      er = '0;
      edz = 1'b0;
    end else if (!bm && start) begin
      model(A, B, pq, pr);
      pdz = B == '0;
      edz = 1'b0;
      done_at = cyc + ((B == '0) ? 1 : N);
      bm = 1'b1;
    end else if (bm && cyc == done_at) begin
      eq = pq;
      er = pr;
      edz = pdz;
    end else if (bm && cyc == done_at + 1) begin
      bm = 1'b0;
    end
    #1;
    if (done === 1'b1) dones++;
    chk("busy", busy, bm);
    chk("done", done, bm && cyc == done_at);
    chk("Q", Q, eq);
    chk("R", R, er);
    chk("div_by_zero", div_by_zero, edz);
  end

  task automatic op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] xq,
                    input logic [N-1:0] xr, input logic xdz, input int xlat);
    int lat;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < N + 4) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, xlat);
    chk("op_Q", Q, xq);
    chk("op_R", R, xr);
    chk("op_dz", div_by_zero, xdz);
  endtask

  initial begin
    logic [N-1:0] a, b, q, r;
    int d0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_Q", Q, 0);
    chk("reset_busy", busy, 0);
`ifndef SIGNED_DIV_EN
    op(100, 7, 14, 2, 0, N);
    op(255, 1, 255, 0, 0, N);
    op(5, 10, 0, 5, 0, N);
    op(0, 3, 0, 0, 0, N);
    op(77, 0, 255, 77, 1, 1);
    op(9, 3, 3, 0, 0, N);
    d0 = dones;
    @(negedge clk);
    A = 200;
    B = 9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    A = 1;
    B = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (N + 4) @(negedge clk);
    chk("ignored_start_Q", Q, 22);
    chk("ignored_start_R", R, 2);
    chk("ignored_start_dones", dones - d0, 1);
    d0 = dones;
    A = 50;
    B = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_Q", Q, 0);
    chk("abort_R", R, 0);
    chk("abort_busy", busy, 0);
    repeat (N + 4) @(negedge clk);
    chk("abort_dones", dones - d0, 0);
    for (int i = 0; i < 1000; i++) begin
      a = N'($urandom);
      b = (i % 40 == 0) ? '0 : N'($urandom);
      model(a, b, q, r);
      op(a, b, q, r, b == '0, (b == '0) ? 1 : N);
    end
`else
    op(8'h9C, 7, 8'hF2, 8'hFE, 0, N);
    op(100, 8'hF9, 8'hF2, 2, 0, N);
    op(8'h80, 8'hFF, 8'h80, 0, 0, N);
    op(8'hB3, 0, 8'hFF, 8'hB3, 1, 1);
    op(8'hF7, 3, 8'hFD, 0, 0, N);
`endif
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
